sprite_draw_fsm: RTL and testbench

- Sequencer that repaints a moving sprite into the vga_adapter framebuffer.
- On each accepted move request it erases the sprite's previous bounding box, then copies the sprite ROM into the box at the new position, one pixel per clock.
- Sits between the position/movement logic (upstream: new_x, new_y, start) and vga_adapter (downstream: x, y, colour, plot).
- It also drives the address of the synchronous single-port sprite ROM.

---
 rtl/sprite_draw_fsm.sv | 174 +++++++++++++++++
 tb/tb_sprite_draw_fsm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_draw_fsm.sv
// sprite_draw_fsm: repaints a moving sprite into the vga_adapter framebuffer.
// For each accepted move request it erases the previous bounding box, then
// copies the sprite ROM into the box at the new position, one pixel per clock.
module sprite_draw_fsm #(
    parameter int unsigned XSCREEN  = 160,
    parameter int unsigned YSCREEN  = 120,
    parameter int unsigned SPRITE_W = 30,
    parameter int unsigned SPRITE_H = 30,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned COLOUR_W = 3,
    parameter logic [COLOUR_W-1:0] ERASE_COLOUR  = '0,
    parameter bit                  TRANSP_EN     = 1'b1,
    parameter logic [COLOUR_W-1:0] TRANSP_COLOUR = '1
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                start,
    input  logic [7:0]          new_x,
    input  logic [6:0]          new_y,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam int unsigned CW = $clog2(SPRITE_W + 1);
    localparam int unsigned RW = $clog2(SPRITE_H + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic                gap;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          cur_x, old_x, base_x;
    logic [6:0]          cur_y, old_y, base_y;
    logic                has_drawn;
    logic                plot_q, draw_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                emit, emit_draw, last_px, on_screen, transparent;
    logic [8:0]          px;
    logic [7:0]          py;

    assign last_px   = (col == COL_LAST) && (row == ROW_LAST);
    assign base_x    = (state == S_ERASE) ? old_x : cur_x;
    assign base_y    = (state == S_ERASE) ? old_y : cur_y;
    assign px        = {1'b0, base_x} + 9'(col);
    assign py        = {1'b0, base_y} + 8'(row);
    assign on_screen = (px < 9'(XSCREEN)) && (py < 8'(YSCREEN));

    assign rom_address = addr;

    // Draw pixels take their colour straight from the registered ROM output,
    // which lines up with the coordinate/valid stage registered alongside it.
    assign transparent = TRANSP_EN && (rom_q == TRANSP_COLOUR);
    assign vga_colour  = draw_q ? rom_q : colour_q;
    assign vga_plot    = plot_q && !(draw_q && transparent);

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= next_state;
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        emit       = 1'b0;
        emit_draw  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) next_state = has_drawn ? S_ERASE : S_DRAW;
            end
            S_ERASE: begin
                busy = 1'b1;
                // The turnaround cycle after the last erase pixel is the ROM
                // bubble: nothing is emitted while the first address is issued.
                if (gap) next_state = S_DRAW;
                else     emit = 1'b1;
            end
            S_DRAW: begin
                busy      = 1'b1;
                emit      = 1'b1;
                emit_draw = 1'b1;
                if (last_px) next_state = S_FLUSH;
            end
            S_FLUSH: begin
                busy       = 1'b1;
                next_state = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Scan counters, ROM address, position bookkeeping and the pixel output stage.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            col       <= '0;
            row       <= '0;
            gap       <= 1'b0;
            addr      <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            old_x     <= '0;
            old_y     <= '0;
            has_drawn <= 1'b0;
            vga_x     <= '0;
            vga_y     <= '0;
            plot_q    <= 1'b0;
            draw_q    <= 1'b0;
            colour_q  <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                cur_x <= new_x;
                cur_y <= new_y;
            end

            if (emit) begin
                if (last_px) begin
                    col <= '0;
                    row <= '0;
                end else if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            gap <= (state == S_ERASE) && !gap && last_px;

            if (state == S_DRAW && !last_px) addr <= addr + ADDR_W'(1);
            else                             addr <= '0;

            if (emit) begin
                vga_x  <= px[7:0];
                vga_y  <= py[6:0];
                plot_q <= on_screen;
                draw_q <= emit_draw;
                if (!emit_draw) colour_q <= ERASE_COLOUR;
            end else begin
                plot_q <= 1'b0;
                draw_q <= 1'b0;
            end

            if (state == S_FLUSH) begin
                old_x     <= cur_x;
                old_y     <= cur_y;
                has_drawn <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_draw_fsm.sv
// Self-checking bench for sprite_draw_fsm: a behavioural model lists every
// pixel a request should plot (cycle, x, y, colour) and the done latency.
module tb_sprite_draw_fsm;

    localparam int W = 30;
    localparam int H = 30;
    localparam int N = W * H;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       start    = 1'b0;
    logic [7:0] new_x    = '0;
    logic [6:0] new_y    = '0;
    logic       busy, done;
    logic [9:0] rom_address;
    logic [2:0] rom_q;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    sprite_draw_fsm #(
        .XSCREEN (160),
        .YSCREEN (120),
        .SPRITE_W(W),
        .SPRITE_H(H)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .start      (start),
        .new_x      (new_x),
        .new_y      (new_y),
        .busy       (busy),
        .done       (done),
        .rom_address(rom_address),
        .rom_q      (rom_q),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Synchronous single-port sprite ROM.
    logic [2:0] rom [0:1023];
    always @(posedge CLOCK_50) rom_q <= rom[rom_address];

    int unsigned tick = 0;
    always @(posedge CLOCK_50) tick <= tick + 1;

    typedef struct { int n; int x; int y; int c; } pix_t;
    typedef struct { int x; int y; int mode; int exp_lat; int exp_plots; } vec_t;

    pix_t exp_q[$];
    pix_t act_q[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    bit   m_has    = 1'b0;
    int   m_ox     = 0;
    int   m_oy     = 0;

    task automatic chk(input string name, input int act, input int expv);
        tot_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    task automatic fill_rom(input int mode);
        for (int a = 0; a < 1024; a++) begin
            case (mode)
                0:       rom[a] = 3'(a % 7);
                1:       rom[a] = (a == 0) ? 3'b010 : 3'b111;
                default: rom[a] = 3'($urandom_range(0, 7));
            endcase
        end
    endtask

    // Expected plots: optional erase of the previous box, then the sprite,
    // clipped to the screen and with transparent pixels dropped. Cycle n counts
    // falling edges after the accepting rising edge.
    task automatic build_exp(input int x, input int y, output int lat);
        int base;
        exp_q.delete();
        base = 2;
        if (m_has) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    if (m_ox + c < 160 && m_oy + r < 120)
                        exp_q.push_back('{2 + r * W + c, m_ox + c, m_oy + r, 0});
            base = N + 3;
        end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                int a;
                a = r * W + c;
                if (x + c < 160 && y + r < 120 && int'(rom[a]) != 7)
                    exp_q.push_back('{base + a, x + c, y + r, int'(rom[a])});
            end
        lat = m_has ? 2 * N + 3 : N + 2;
    endtask

    // One request: start is driven so the next rising edge accepts it.
    // intr_n > 0 pulses start (with a different x) at that cycle of the request.
    task automatic run_req(input string tag, input int x, input int y, input bit hold,
                           input int intr_n, output int lat, output int nplots,
                           output int done_tick);
        int n, bd, mism, exp_lat, lim;
        build_exp(x, y, exp_lat);
        act_q.delete();
        new_x = 8'(x);
        new_y = 7'(y);
        start = 1'b1;
        @(posedge CLOCK_50);
        n = 0; lat = -1; bd = 0; done_tick = -1;
        while (lat < 0 && n < 4000) begin
            @(negedge CLOCK_50);
            n++;
            if (!hold) start = (n == intr_n);
            if (n == intr_n) new_x = new_x + 8'd37;
            if (vga_plot) act_q.push_back('{n, int'(vga_x), int'(vga_y), int'(vga_colour)});
            if (busy && done) bd++;
            if (done) begin
                lat = n;
                done_tick = int'(tick);
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_with_done"}, bd, 0);
        chk({tag, "_plot_count"}, act_q.size(), exp_q.size());
        mism = 0;
        lim = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            if (act_q[i] != exp_q[i]) begin
                if (mism == 0)
                    $display("  %s first differing plot #%0d: got n=%0d (%0d,%0d) c=%0d, want n=%0d (%0d,%0d) c=%0d",
                             tag, i, act_q[i].n, act_q[i].x, act_q[i].y, act_q[i].c,
                             exp_q[i].n, exp_q[i].x, exp_q[i].y, exp_q[i].c);
                mism++;
            end
        end
        chk({tag, "_plot_content"}, mism, 0);
        nplots = act_q.size();
        m_has = 1'b1;
        m_ox  = x;
        m_oy  = y;
        @(negedge CLOCK_50);
    endtask

    initial begin
        vec_t vt[5];
        int lat, np, t1, t2, t3, extra;

        vt[0] = '{10,  5,   0, N + 2,     900};
        vt[1] = '{20,  5,   0, 2 * N + 3, 1800};
        vt[2] = '{150, 110, 0, 2 * N + 3, 1000};
        vt[3] = '{40,  40,  1, 2 * N + 3, 101};
        vt[4] = '{159, 119, 0, 2 * N + 3, 901};

        fill_rom(0);
        resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_plot", vga_plot, 0);
        chk("rst_vga_x", vga_x, 0);
        chk("rst_vga_y", vga_y, 0);
        chk("rst_colour", vga_colour, 0);
        chk("rst_rom_address", rom_address, 0);
        resetn = 1'b1;
        @(negedge CLOCK_50);

        for (int i = 0; i < 5; i++) begin
            fill_rom(vt[i].mode);
            run_req($sformatf("vec%0d", i), vt[i].x, vt[i].y, 1'b0, -1, lat, np, t1);
            chk($sformatf("vec%0d_table_latency", i), lat, vt[i].exp_lat);
            chk($sformatf("vec%0d_table_plots", i), np, vt[i].exp_plots);
        end

        // start pulsed during erase must be ignored and leave no extra done.
        fill_rom(0);
        run_req("ignore", 60, 30, 1'b0, 100, lat, np, t1);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            if (done || busy) extra++;
        end
        chk("ignore_no_extra_activity", extra, 0);

        // Reset mid-draw aborts at once and clears the drawn history.
        new_x = 8'd5; new_y = 7'd5; start = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (N + 300) @(negedge CLOCK_50);
        chk("middraw_busy", busy, 1);
        resetn = 1'b0;
        #1;
        chk("abort_plot", vga_plot, 0);
        chk("abort_busy", busy, 0);
        extra = 0;
        repeat (3) begin
            @(negedge CLOCK_50);
            if (vga_plot) extra++;
        end
        chk("abort_no_plots", extra, 0);
        resetn = 1'b1;
        m_has  = 1'b0;
        @(negedge CLOCK_50);
        run_req("after_rst", 70, 60, 1'b0, -1, lat, np, t1);
        chk("after_rst_no_erase_latency", lat, N + 2);

        // Back-to-back requests with start held high.
        run_req("b2b0", 90, 70, 1'b1, -1, lat, np, t1);
        run_req("b2b1", 90, 70, 1'b1, -1, lat, np, t2);
        run_req("b2b2", 90, 70, 1'b1, -1, lat, np, t3);
        start = 1'b0;
        chk("b2b_spacing_1", t2 - t1, 2 * N + 4);
        chk("b2b_spacing_2", t3 - t2, 2 * N + 4);

        // Randomised positions and ROM contents against the model.
        for (int i = 0; i < 4; i++) begin
            fill_rom(2);
            run_req($sformatf("rand%0d", i), $urandom_range(0, 175), $urandom_range(0, 127),
                    1'b0, -1, lat, np, t1);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
